// File: rtl/binary_gray_pkg.sv
// Shared types and constants for the time-shared binary/Gray conversion block.
package binary_gray_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;

endpackage

// File: rtl/binary_gray_convert_core.sv
// Purely combinational binary<->Gray converter; direction chosen by mode.
module binary_gray_convert_core
  import binary_gray_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] to_gray;
  logic [DATA_WIDTH-1:0] to_bin;

  assign to_gray = data ^ (data >> 1);

  // Each binary bit is the XOR of all Gray bits at or above it; written as a
  // reduction per bit so no bit depends on another output bit.
  always_comb begin
    to_bin = '0;
    for (int unsigned k = 0; k < unsigned'(DATA_WIDTH); k++) begin
      to_bin[k] = ^(data >> k);
    end
  end

  assign result = (mode == MODE_GRAY2BIN) ? to_bin : to_gray;

endmodule

// File: rtl/binary_gray_converter_arbiter.sv
// Round-robin arbitrated binary/Gray converter shared by NUM_REQ requesters,
// with capture -> convert -> held response sequencing.
module binary_gray_converter_arbiter
  import binary_gray_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          Clock_In,
  input  logic                          Reset_In,
  input  logic [NUM_REQ-1:0]            Req_Valid_In,
  output logic [NUM_REQ-1:0]            Req_Ready_Out,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
  input  logic [NUM_REQ-1:0]            Req_Mode_In,
  output logic                          Resp_Valid_Out,
  input  logic                          Resp_Ready_In,
  output logic [DATA_WIDTH-1:0]         Resp_Data_Out,
  output logic [ID_WIDTH-1:0]           Resp_Id_Out,
  output logic                          Resp_Mode_Out,
  output logic                          Busy_Out
);

  state_t state_q, state_d;

  logic [ID_WIDTH-1:0]   last_grant_q;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic                  grant_valid;
  logic                  req_handshake;

  logic [DATA_WIDTH-1:0] in_data_q;
  logic                  in_mode_q;
  logic [ID_WIDTH-1:0]   in_id_q;
  logic [DATA_WIDTH-1:0] conv_result;

  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic                  out_mode_q;

  // Rotating priority: scan last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ),
  // so the most recently served requester is considered last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= unsigned'(NUM_REQ); i++) begin
      cand = ID_WIDTH'((32'(last_grant_q) + i) % unsigned'(NUM_REQ));
      if (!grant_valid && Req_Valid_In[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign req_handshake = (state_q == IDLE) && grant_valid;

  always_comb begin
    Req_Ready_Out = '0;
    if (req_handshake) begin
      Req_Ready_Out[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_handshake) state_d = CONVERT;
      CONVERT: state_d = HOLD;
      HOLD:    if (Resp_Ready_In) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  binary_gray_convert_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .data  (in_data_q),
    .mode  (in_mode_q),
    .result(conv_result)
  );

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q      <= IDLE;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      in_data_q    <= '0;
      in_mode_q    <= MODE_BIN2GRAY;
      in_id_q      <= '0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      out_mode_q   <= MODE_BIN2GRAY;
    end else begin
      state_q <= state_d;
      if (req_handshake) begin
        last_grant_q <= grant_idx;
        in_data_q    <= Req_Data_In[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        in_mode_q    <= Req_Mode_In[grant_idx];
        in_id_q      <= grant_idx;
      end
      if (state_q == CONVERT) begin
        out_data_q <= conv_result;
        out_id_q   <= in_id_q;
        out_mode_q <= in_mode_q;
      end
    end
  end

  assign Resp_Valid_Out = (state_q == HOLD);
  assign Resp_Data_Out  = out_data_q;
  assign Resp_Id_Out    = out_id_q;
  assign Resp_Mode_Out  = out_mode_q;
  assign Busy_Out       = (state_q != IDLE);

endmodule

// File: tb/tb_binary_gray_converter_arbiter.sv
// Directed self-checking bench: 4x32-bit instance for arbitration/timing,
// 2x8-bit instance for an exhaustive round-trip sweep.
module tb_binary_gray_converter_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [3:0]   req_mode;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_id;
  logic         resp_mode;
  logic         busy;

  logic [1:0]   valid8;
  logic [1:0]   ready8;
  logic [15:0]  data8;
  logic [1:0]   mode8;
  logic         resp_valid8;
  logic [7:0]   resp_data8;
  logic [0:0]   resp_id8;
  logic         resp_mode8;
  logic         busy8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  binary_gray_converter_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(32)
  ) u_dut (
    .Clock_In      (clk),
    .Reset_In      (rst),
    .Req_Valid_In  (req_valid),
    .Req_Ready_Out (req_ready),
    .Req_Data_In   (req_data),
    .Req_Mode_In   (req_mode),
    .Resp_Valid_Out(resp_valid),
    .Resp_Ready_In (resp_ready),
    .Resp_Data_Out (resp_data),
    .Resp_Id_Out   (resp_id),
    .Resp_Mode_Out (resp_mode),
    .Busy_Out      (busy)
  );

  binary_gray_converter_arbiter #(
    .NUM_REQ   (2),
    .DATA_WIDTH(8)
  ) u_dut8 (
    .Clock_In      (clk),
    .Reset_In      (rst),
    .Req_Valid_In  (valid8),
    .Req_Ready_Out (ready8),
    .Req_Data_In   (data8),
    .Req_Mode_In   (mode8),
    .Resp_Valid_Out(resp_valid8),
    .Resp_Ready_In (1'b1),
    .Resp_Data_Out (resp_data8),
    .Resp_Id_Out   (resp_id8),
    .Resp_Mode_Out (resp_mode8),
    .Busy_Out      (busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a single requester, confirm it alone is granted, complete the
  // handshake; returns in the first cycle after capture.
  task automatic send(input int id, input logic [31:0] d, input logic m);
    logic hs;
    hs = 1'b0;
    req_valid[id] = 1'b1;
    req_data[id*32 +: 32] = d;
    req_mode[id] = m;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready[id]) begin
        hs = 1'b1;
        break;
      end
      tick();
    end
    check("grant_onehot", 32'(req_ready), 32'(4'b0001 << id));
    check("grant_seen", 32'(hs), 32'd1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(output int cycles);
    cycles = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) break;
      tick();
      cycles++;
    end
    check("resp_valid_wait", 32'(resp_valid), 32'd1);
  endtask

  task automatic conv8(input logic [7:0] x, input logic m, output logic [7:0] y);
    logic hs;
    hs = 1'b0;
    valid8 = 2'b01;
    data8  = {8'h00, x};
    mode8  = {1'b0, m};
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ready8[0]) begin
        hs = 1'b1;
        break;
      end
      tick();
    end
    if (!hs) check("sweep_grant_timeout", 32'(hs), 32'd1);
    tick();
    valid8 = 2'b00;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid8) break;
      tick();
    end
    if (!resp_valid8) check("sweep_resp_timeout", 32'(resp_valid8), 32'd1);
    y = resp_data8;
    tick();
  endtask

  logic [31:0] rr_data [4];
  logic [31:0] rr_exp  [4];
  int          cyc;
  logic [7:0]  y8, z8, g8, x8;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_mode   = '0;
    resp_ready = 1'b0;
    valid8     = '0;
    data8      = '0;
    mode8      = '0;
    tick();
    tick();

    // Reset state
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_mode", 32'(resp_mode), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Binary->Gray 5 -> 7 from requester 0, response two cycles after handshake
    send(0, 32'h0000_0005, 1'b0);
    check("lat_convert_valid", 32'(resp_valid), 32'd0);
    check("lat_convert_busy", 32'(busy), 32'd1);
    check("lat_convert_ready", 32'(req_ready), 32'd0);
    tick();
    check("lat_hold_valid", 32'(resp_valid), 32'd1);
    check("b2g_5_data", resp_data, 32'h0000_0007);
    check("b2g_5_id", 32'(resp_id), 32'd0);
    check("b2g_5_mode", 32'(resp_mode), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("after_resp_valid", 32'(resp_valid), 32'd0);
    check("after_resp_busy", 32'(busy), 32'd0);

    // Gray->binary MSB-only word, then Binary->Gray all-ones
    send(2, 32'h8000_0000, 1'b1);
    wait_resp(cyc);
    check("g2b_msb_data", resp_data, 32'hFFFF_FFFF);
    check("g2b_msb_id", 32'(resp_id), 32'd2);
    check("g2b_msb_mode", 32'(resp_mode), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    send(3, 32'hFFFF_FFFF, 1'b0);
    wait_resp(cyc);
    check("b2g_ones_data", resp_data, 32'h8000_0000);
    check("b2g_ones_id", 32'(resp_id), 32'd3);
    resp_ready = 1'b1;
    tick();

    // All four valid with ready held high: round-robin 0,1,2,3,0,1
    rr_data = '{32'h0000_000F, 32'h0000_0003, 32'h0000_00FF, 32'hC000_0000};
    rr_exp  = '{32'h0000_0008, 32'h0000_0002, 32'h0000_0080, 32'h8000_0000};
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = rr_data[i];
    req_mode  = 4'b1010;
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_resp(cyc);
      check("rr_id", 32'(resp_id), 32'(n % 4));
      check("rr_data", resp_data, rr_exp[n % 4]);
      if (n > 0) check("rr_spacing", 32'(cyc), 32'd2);
      tick();
    end
    req_valid = '0;
    req_mode  = '0;
    resp_ready = 1'b0;

    // Backpressure: result from requester 1 held while 1 and 3 wait
    send(1, 32'h0000_0006, 1'b0);
    req_data[1*32 +: 32] = 32'h0000_0006;
    req_data[3*32 +: 32] = 32'h0000_000A;
    req_valid = 4'b1010;
    tick();
    for (int n = 0; n < 5; n++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_data", resp_data, 32'h0000_0005);
      check("bp_id", 32'(resp_id), 32'd1);
      check("bp_mode", 32'(resp_mode), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("bp_next_grant", 32'(req_ready), 32'b1000);
    tick();
    wait_resp(cyc);
    check("bp_next_id", 32'(resp_id), 32'd3);
    check("bp_next_data", resp_data, 32'h0000_000F);
    req_valid = '0;
    tick();
    resp_ready = 1'b0;

    // Reset during CONVERT
    send(0, 32'h0000_0002, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cv_valid", 32'(resp_valid), 32'd0);
    check("rst_cv_busy", 32'(busy), 32'd0);
    tick();
    check("rst_cv_no_resp", 32'(resp_valid), 32'd0);

    // Reset during HOLD
    send(2, 32'h0000_0002, 1'b0);
    tick();
    check("rst_hd_pre_valid", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_hd_valid", 32'(resp_valid), 32'd0);
    check("rst_hd_busy", 32'(busy), 32'd0);
    check("rst_hd_data", resp_data, 32'd0);

    // Reset wins over a simultaneous request handshake
    req_valid = 4'b0010;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    check("rst_hs_busy", 32'(busy), 32'd0);
    tick();
    check("rst_hs_still_idle", 32'(busy), 32'd0);

    // Post-reset arbitration starts at requester 0
    req_data[0*32 +: 32] = 32'h0000_0002;
    req_data[1*32 +: 32] = 32'h0000_0004;
    req_mode  = 4'b0000;
    req_valid = 4'b0011;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_resp(cyc);
    check("post_rst_id", 32'(resp_id), 32'd0);
    check("post_rst_data", resp_data, 32'h0000_0003);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // 8-bit exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      x8 = 8'(v);
      conv8(x8, 1'b1, y8);
      conv8(y8, 1'b0, z8);
      check("sweep_roundtrip", 32'(z8), 32'(x8));
      conv8(x8, 1'b0, g8);
      check("sweep_b2g", 32'(g8), 32'(x8 ^ (x8 >> 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
